// File: rtl/pe_mac_burst_if.sv
// pe_mac_burst_if: operand stream into a burst MAC processing element and the
// neighbour-forwarding / result signals coming back out of it.
//
// Handshake: there is no backpressure. fire qualifies a/w in the cycle it is
// high. out_v is a one-cycle pulse that qualifies out/out_n/out_ovf, which then
// hold their value until the next pulse. out_f/out_a/out_w are a plain one-cycle
// delayed copy of fire/a/w for the east/south neighbour.
interface pe_mac_burst_if #(
  parameter int DW   = 8,
  parameter int ACCW = 32,
  parameter int CW   = 8
);
  logic            fire;
  logic [DW-1:0]   a;
  logic [DW-1:0]   w;
  logic            out_f;
  logic [DW-1:0]   out_a;
  logic [DW-1:0]   out_w;
  logic [ACCW-1:0] out;
  logic            out_v;
  logic [CW-1:0]   out_n;
  logic            out_ovf;

  // Upstream side: drives operands, observes forwarded copies and results.
  modport master (
    output fire, a, w,
    input  out_f, out_a, out_w, out, out_v, out_n, out_ovf
  );

  // Processing element side.
  modport slave (
    input  fire, a, w,
    output out_f, out_a, out_w, out, out_v, out_n, out_ovf
  );
endinterface

// File: rtl/pe_mac_burst.sv
// pe_mac_burst: systolic processing element that multiply-accumulates bursts of
// fire-qualified activation/weight pairs, reports each burst's dot product with a
// one-cycle out_v pulse plus a product count, then self-clears for the next burst.
// Two pipeline stages: a registered product, then an IDLE/ACC/DONE accumulator FSM.
// Build option: define SYSTOLA_PE_SAT_EN to make the accumulator saturate instead
// of wrapping (out_ovf is reported either way).
module pe_mac_burst #(
  parameter int DW     = 8,
  parameter int ACCW   = 32,
  parameter int SIGNED = 0,
  parameter int CW     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  pe_mac_burst_if.slave       pe,
  output logic [1:0]          dbg_state_o
);

  localparam int PW = 2 * DW;
  localparam int XW = ACCW - PW;

  generate
    if (ACCW < PW) begin : g_bad_accw
      $error("pe_mac_burst: ACCW must be at least 2*DW");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Neighbour forwarding registers
  logic          out_f_q;
  logic [DW-1:0] out_a_q;
  logic [DW-1:0] out_w_q;

  // Product stage
  logic            sx_a;
  logic            sx_w;
  logic [PW-1:0]   op_a;
  logic [PW-1:0]   op_w;
  logic [PW-1:0]   mul;
  logic [ACCW-1:0] prod_ext;
  logic [ACCW-1:0] p_q;
  logic            pv_q;

  // Accumulator stage
  state_t          state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [ACCW-1:0] res_q, res_d;
  logic [CW-1:0]   res_n_q, res_n_d;
  logic            res_ovf_q, res_ovf_d;
  logic            out_v_q, out_v_d;
`ifdef SYSTOLA_PE_SAT_EN
  logic            sat_q, sat_d;
`endif

  // Adder of the accumulate step
  logic [ACCW:0]   sum_w;
  logic            sov;
  logic            add_ovf;
  logic [ACCW-1:0] add_val;
  logic [CW-1:0]   cnt_inc;

  // Operands are extended to 2*DW so one unsigned multiplier serves both modes:
  // the low 2*DW bits of a product of sign-extended operands equal the signed product.
  assign sx_a = (SIGNED != 0) && pe.a[DW-1];
  assign sx_w = (SIGNED != 0) && pe.w[DW-1];
  assign op_a = {{DW{sx_a}}, pe.a};
  assign op_w = {{DW{sx_w}}, pe.w};
  assign mul  = op_a * op_w;

  generate
    if (XW > 0) begin : g_ext
      assign prod_ext = {{XW{(SIGNED != 0) && mul[PW-1]}}, mul};
    end else begin : g_noext
      assign prod_ext = mul;
    end
  endgenerate

  // Forward operands and fire to the neighbours every cycle, fire or not
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_f_q <= 1'b0;
      out_a_q <= '0;
      out_w_q <= '0;
    end else begin
      out_f_q <= pe.fire;
      out_a_q <= pe.a;
      out_w_q <= pe.w;
    end
  end

  // Product stage: register the extended product (zero when not firing)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q  <= '0;
      pv_q <= 1'b0;
    end else begin
      p_q  <= pe.fire ? prod_ext : '0;
      pv_q <= pe.fire;
    end
  end

  // Accumulate-step arithmetic: overflow detection and optional clamping
  always_comb begin
    sum_w   = {1'b0, acc_q} + {1'b0, p_q};
    sov     = (acc_q[ACCW-1] == p_q[ACCW-1]) && (sum_w[ACCW-1] != acc_q[ACCW-1]);
    add_ovf = (SIGNED != 0) ? sov : sum_w[ACCW];
    add_val = sum_w[ACCW-1:0];
    cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
`ifdef SYSTOLA_PE_SAT_EN
    if (sat_q) begin
      add_val = acc_q;
    end else if (add_ovf) begin
      if (SIGNED != 0) begin
        add_val = acc_q[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      end else begin
        add_val = {ACCW{1'b1}};
      end
    end
`endif
  end

  // Accumulator FSM: next state, datapath updates and result capture
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_n_d   = res_n_q;
    res_ovf_d = res_ovf_q;
    out_v_d   = 1'b0;
`ifdef SYSTOLA_PE_SAT_EN
    sat_d     = sat_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // A burst may start straight out of DONE, so both states load alike
        if (pv_q) begin
          acc_d   = p_q;
          cnt_d   = CW'(1);
          ovf_d   = 1'b0;
`ifdef SYSTOLA_PE_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (pv_q) begin
          acc_d = add_val;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
`ifdef SYSTOLA_PE_SAT_EN
          sat_d = sat_q | add_ovf;
`endif
        end else begin
          res_d     = acc_q;
          res_n_d   = cnt_q;
          res_ovf_d = ovf_q;
          acc_d     = '0;
          out_v_d   = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator FSM state and result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_n_q   <= '0;
      res_ovf_q <= 1'b0;
      out_v_q   <= 1'b0;
`ifdef SYSTOLA_PE_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_n_q   <= res_n_d;
      res_ovf_q <= res_ovf_d;
      out_v_q   <= out_v_d;
`ifdef SYSTOLA_PE_SAT_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign pe.out_f    = out_f_q;
  assign pe.out_a    = out_a_q;
  assign pe.out_w    = out_w_q;
  assign pe.out      = res_q;
  assign pe.out_n    = res_n_q;
  assign pe.out_ovf  = res_ovf_q;
  assign pe.out_v    = out_v_q;
  assign dbg_state_o = state_q;

endmodule
